// File: rtl/mat_loader.sv
// Host-side loader for the matrix unit. It assembles framed 32-bit host words into
// instruction and data rows, writes them to the memories, and sequences the controller run.
//   state     | meaning
//   S_IDLE    | waiting for a header word
//   S_ADDR    | waiting for the base row address
//   S_PAYLOAD | collecting beats of the current row
//   S_WRITE   | one-cycle write strobe for the assembled row
//   S_RUN     | controller released from reset, waiting for done
module mat_loader #(
    parameter int WIDTH                = 16,
    parameter int INST_MEM_ADDR_SIZE   = 32,
    parameter int DATA_MEM_ADDR_SIZE   = 32,
    parameter int INST_MEM_WIDTH_BYTES = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [31:0]                       in_data,
    output logic                              inst_mem_write_en,
    output logic [INST_MEM_ADDR_SIZE-1:0]     inst_mem_write_addr,
    output logic [8*INST_MEM_WIDTH_BYTES-1:0] inst_mem_data_in,
    output logic                              data_mem_write_en,
    output logic [DATA_MEM_ADDR_SIZE-1:0]     data_mem_write_addr,
    output logic [32*WIDTH-1:0]               data_mem_data_in,
    output logic                              control_reset,
    input  logic                              done,
    output logic                              run_done
);

    localparam int INST_BEATS = INST_MEM_WIDTH_BYTES / 4;
    localparam int INST_W     = 8 * INST_MEM_WIDTH_BYTES;
    localparam int DATA_W     = 32 * WIDTH;
    localparam int BUF_W      = (DATA_W > INST_W) ? DATA_W : INST_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_PAYLOAD,
        S_WRITE,
        S_RUN
    } state_t;

    state_t                        state_q, state_d;
    logic                          is_data_q, is_data_d;
    logic [15:0]                   count_q, count_d;
    logic [15:0]                   row_q, row_d;
    logic [15:0]                   beat_q, beat_d;
    logic [BUF_W-1:0]              buf_q, buf_d;
    logic [INST_MEM_ADDR_SIZE-1:0] iptr_q, iptr_d;
    logic [DATA_MEM_ADDR_SIZE-1:0] dptr_q, dptr_d;
    logic [INST_MEM_ADDR_SIZE-1:0] iaddr_q, iaddr_d;
    logic [DATA_MEM_ADDR_SIZE-1:0] daddr_q, daddr_d;
    logic [INST_W-1:0]             idata_q, idata_d;
    logic [DATA_W-1:0]             ddata_q, ddata_d;
    logic                          iwe_q, iwe_d;
    logic                          dwe_q, dwe_d;
    logic                          crst_q, crst_d;
    logic                          rdone_q, rdone_d;

    logic        accept;
    logic [15:0] last_idx;

    assign in_ready = !reset && (state_q inside {S_IDLE, S_ADDR, S_PAYLOAD});
    assign accept   = in_valid && in_ready;
    assign last_idx = is_data_q ? 16'(WIDTH - 1) : 16'(INST_BEATS - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            is_data_q <= 1'b0;
            count_q   <= '0;
            row_q     <= '0;
            beat_q    <= '0;
            buf_q     <= '0;
            iptr_q    <= '0;
            dptr_q    <= '0;
            iaddr_q   <= '0;
            daddr_q   <= '0;
            idata_q   <= '0;
            ddata_q   <= '0;
            iwe_q     <= 1'b0;
            dwe_q     <= 1'b0;
            crst_q    <= 1'b1;
            rdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_data_q <= is_data_d;
            count_q   <= count_d;
            row_q     <= row_d;
            beat_q    <= beat_d;
            buf_q     <= buf_d;
            iptr_q    <= iptr_d;
            dptr_q    <= dptr_d;
            iaddr_q   <= iaddr_d;
            daddr_q   <= daddr_d;
            idata_q   <= idata_d;
            ddata_q   <= ddata_d;
            iwe_q     <= iwe_d;
            dwe_q     <= dwe_d;
            crst_q    <= crst_d;
            rdone_q   <= rdone_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        is_data_d = is_data_q;
        count_d   = count_q;
        row_d     = row_q;
        beat_d    = beat_q;
        buf_d     = buf_q;
        iptr_d    = iptr_q;
        dptr_d    = dptr_q;
        iaddr_d   = iaddr_q;
        daddr_d   = daddr_q;
        idata_d   = idata_q;
        ddata_d   = ddata_q;
        iwe_d     = 1'b0;
        dwe_d     = 1'b0;
        crst_d    = crst_q;
        rdone_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    count_d = in_data[15:0];
                    case (in_data[31:30])
                        2'b00: begin
                            is_data_d = 1'b0;
                            state_d   = S_ADDR;
                        end
                        2'b01: begin
                            is_data_d = 1'b1;
                            state_d   = S_ADDR;
                        end
                        2'b11: begin
                            crst_d  = 1'b0;
                            state_d = S_RUN;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_ADDR: begin
                if (accept) begin
                    row_d  = '0;
                    beat_d = '0;
                    if (is_data_q)
                        dptr_d = DATA_MEM_ADDR_SIZE'(in_data);
                    else
                        iptr_d = INST_MEM_ADDR_SIZE'(in_data);
                    state_d = (count_q == 16'd0) ? S_IDLE : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    buf_d[32*beat_q +: 32] = in_data;
                    if (beat_q == last_idx) begin
                        // Strobe, address and data are registered together so the
                        // write lands in the cycle after the last beat is accepted.
                        beat_d  = '0;
                        state_d = S_WRITE;
                        if (is_data_q) begin
                            dwe_d   = 1'b1;
                            daddr_d = dptr_q;
                            ddata_d = buf_d[DATA_W-1:0];
                        end else begin
                            iwe_d   = 1'b1;
                            iaddr_d = iptr_q;
                            idata_d = buf_d[INST_W-1:0];
                        end
                    end else begin
                        beat_d = beat_q + 16'd1;
                    end
                end
            end
            S_WRITE: begin
                row_d = row_q + 16'd1;
                if (is_data_q)
                    dptr_d = dptr_q + DATA_MEM_ADDR_SIZE'(1);
                else
                    iptr_d = iptr_q + INST_MEM_ADDR_SIZE'(1);
                // 17-bit compare keeps N = 65535 exact.
                if (({1'b0, row_q} + 17'd1) == {1'b0, count_q})
                    state_d = S_IDLE;
                else
                    state_d = S_PAYLOAD;
            end
            S_RUN: begin
                if (done) begin
                    crst_d  = 1'b1;
                    rdone_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign inst_mem_write_en   = iwe_q;
    assign inst_mem_write_addr = iaddr_q;
    assign inst_mem_data_in    = idata_q;
    assign data_mem_write_en   = dwe_q;
    assign data_mem_write_addr = daddr_q;
    assign data_mem_data_in    = ddata_q;
    assign control_reset       = crst_q;
    assign run_done            = rdone_q;

endmodule
